rr_stream_arbiter: RTL and testbench

- Parametrised N-to-1 stream merger with a FIFO per input and a work-conserving round-robin grant.
- Ready/valid backpressure on both sides.
- Tags each output beat with its source index.
- Sits between parallel producers (rasteriser/shader lanes) and a single downstream consumer (framebuffer writer).

---
 rtl/rr_stream_arbiter_pkg.sv | 38 +++
 rtl/rr_stream_arbiter_if.sv | 27 ++
 rtl/rr_stream_arbiter_fifo.sv | 57 +++++
 rtl/rr_stream_arbiter.sv | 107 ++++++++++
 tb/tb_rr_stream_arbiter.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_stream_arbiter_pkg.sv
// rtl/rr_stream_arbiter_pkg.sv - shared types, constants and round-robin pick function
package rr_arb_pkg;

    localparam int MAX_INPUTS = 16;
    localparam int SRC_IDX_W  = 4;
    localparam int DROP_CNT_W = 16;

    typedef logic [SRC_IDX_W-1:0] src_idx_t;

    typedef struct packed {
        logic     found;
        src_idx_t idx;
    } rr_pick_t;

    // First set bit of nonempty_mask strictly after last, wrapping at num_inputs.
    function automatic rr_pick_t next_rr(input src_idx_t                last,
                                         input logic [MAX_INPUTS-1:0]   nonempty_mask,
                                         input int                      num_inputs);
        rr_pick_t pick;
        int       cand;
        pick.found = 1'b0;
        pick.idx   = last;
        for (int k = 1; k <= MAX_INPUTS; k++) begin
            if (k <= num_inputs && !pick.found) begin
                cand = int'(last) + k;
                if (cand >= num_inputs) begin
                    cand = cand - num_inputs;
                end
                if (nonempty_mask[cand]) begin
                    pick.found = 1'b1;
                    pick.idx   = src_idx_t'(cand);
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_stream_arbiter_if.sv
// rtl/rr_stream_arbiter_if.sv - producer-side and consumer-side stream signals of the arbiter
interface rr_stream_arbiter_if #(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_WIDTH = 64
);
    localparam int SRC_W = $clog2(NUM_INPUTS);

    logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] data_line;
    logic [NUM_INPUTS-1:0]                 valid_array;
    logic [NUM_INPUTS-1:0]                 ready_array;
    logic [NUM_INPUTS-1:0]                 full_array;
    logic [DATA_WIDTH-1:0]                 data_out;
    logic [SRC_W-1:0]                      source_out;
    logic                                  data_valid_out;
    logic                                  receiver_ready;

    modport slave (
        input  data_line, valid_array, receiver_ready,
        output ready_array, full_array, data_out, source_out, data_valid_out
    );

    modport master (
        output data_line, valid_array, receiver_ready,
        input  ready_array, full_array, data_out, source_out, data_valid_out
    );

endinterface

// File: rtl/rr_stream_arbiter_fifo.sv
// rtl/rr_stream_arbiter_fifo.sv - first-word fall-through synchronous FIFO, one per arbiter input
module arb_sync_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  full
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally since FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/rr_stream_arbiter.sv
// rtl/rr_stream_arbiter.sv - N-to-1 round-robin stream merger with per-input FIFOs
// Optional drop counters enabled by RR_ARB_DROP_STATS_EN.
module rr_stream_arbiter
    import rr_arb_pkg::*;
#(
    parameter  int NUM_INPUTS = 4,
    parameter  int DATA_WIDTH = 64,
    parameter  int FIFO_DEPTH = 16,
    localparam int SRC_W      = $clog2(NUM_INPUTS)
) (
    input  logic clk_in,
    input  logic rst_n_in,
    rr_stream_arbiter_if.slave bus
`ifdef RR_ARB_DROP_STATS_EN
    ,
    output logic [NUM_INPUTS-1:0][DROP_CNT_W-1:0] drop_count_out
`endif
);

    logic [NUM_INPUTS-1:0]                 fifo_empty;
    logic [NUM_INPUTS-1:0]                 fifo_full;
    logic [NUM_INPUTS-1:0]                 fifo_pop;
    logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] fifo_dout;

    logic [MAX_INPUTS-1:0] nonempty_mask;
    rr_pick_t              pick;
    logic [SRC_W-1:0]      sel;
    logic                  load;

    logic [DATA_WIDTH-1:0] out_data;
    logic [SRC_W-1:0]      out_src;
    logic                  out_valid;
    src_idx_t              last_grant;

    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_fifo
        arb_sync_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk_in),
            .rst_n (rst_n_in),
            .push  (bus.valid_array[gi]),
            .din   (bus.data_line[gi]),
            .pop   (fifo_pop[gi]),
            .dout  (fifo_dout[gi]),
            .empty (fifo_empty[gi]),
            .full  (fifo_full[gi])
        );
    end

    // Ready comes from registered occupancy only, so a popping full FIFO still reads not-ready.
    assign bus.ready_array    = ~fifo_full;
    assign bus.full_array     = fifo_full;
    assign bus.data_out       = out_data;
    assign bus.source_out     = out_src;
    assign bus.data_valid_out = out_valid;

    assign load = !out_valid || bus.receiver_ready;
    assign sel  = pick.idx[SRC_W-1:0];

    always_comb begin
        nonempty_mask                 = '0;
        nonempty_mask[NUM_INPUTS-1:0] = ~fifo_empty;
        pick                          = next_rr(last_grant, nonempty_mask, NUM_INPUTS);
    end

    always_comb begin
        fifo_pop = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            fifo_pop[i] = load && pick.found && (pick.idx == src_idx_t'(i));
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            out_data   <= '0;
            out_src    <= '0;
            out_valid  <= 1'b0;
            last_grant <= src_idx_t'(NUM_INPUTS - 1);
        end else if (load) begin
            if (pick.found) begin
                out_data   <= fifo_dout[sel];
                out_src    <= sel;
                out_valid  <= 1'b1;
                last_grant <= pick.idx;
            end else begin
                out_valid  <= 1'b0;
            end
        end
    end

`ifdef RR_ARB_DROP_STATS_EN
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            drop_count_out <= '0;
        end else begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (bus.valid_array[i] && fifo_full[i] &&
                    drop_count_out[i] != {DROP_CNT_W{1'b1}}) begin
                    drop_count_out[i] <= drop_count_out[i] + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// tb/tb_rr_stream_arbiter.sv - directed self-checking bench for rr_stream_arbiter
module tb_rr_stream_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int FD = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    rr_stream_arbiter_if #(.NUM_INPUTS(N), .DATA_WIDTH(DW)) bus ();

`ifdef RR_ARB_DROP_STATS_EN
    logic [N-1:0][15:0] drop_count;
`endif

    rr_stream_arbiter #(
        .NUM_INPUTS (N),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
`ifdef RR_ARB_DROP_STATS_EN
        ,
        .drop_count_out (drop_count)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        bus.valid_array    = '0;
        bus.data_line      = '0;
        bus.receiver_ready = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.valid_array    = '0;
        bus.data_line      = '0;
        bus.receiver_ready = 1'b1;
        rst_n = 1'b0;
        tick();
        checks++;
        if (bus.data_valid_out !== 1'b0 || bus.data_out !== 64'h0 || bus.source_out !== 2'd0) begin
            failures++;
            $display("FAIL reset_out: valid=%b data=%h src=%0d, required 0/0/0",
                     bus.data_valid_out, bus.data_out, bus.source_out);
        end
        checks++;
        if (bus.ready_array !== 4'hF || bus.full_array !== 4'h0) begin
            failures++;
            $display("FAIL reset_ready: ready=%h full=%h, required F/0", bus.ready_array, bus.full_array);
        end
`ifdef RR_ARB_DROP_STATS_EN
        checks++;
        if (drop_count !== '0) begin
            failures++;
            $display("FAIL reset_drop: drop_count=%h, required 0", drop_count);
        end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_first_beat();
        apply_reset();
        bus.valid_array[2] = 1'b1;
        bus.data_line[2]   = 64'hA5;
        tick();
        bus.valid_array = '0;
        checks++;
        if (bus.data_valid_out !== 1'b0) begin
            failures++;
            $display("FAIL first_latency: valid=%b after push edge, required 0", bus.data_valid_out);
        end
        tick();
        checks++;
        if (bus.data_valid_out !== 1'b1 || bus.data_out !== 64'hA5 || bus.source_out !== 2'd2) begin
            failures++;
            $display("FAIL first_beat: valid=%b data=%h src=%0d, required 1/a5/2",
                     bus.data_valid_out, bus.data_out, bus.source_out);
        end
        tick();
        checks++;
        if (bus.data_valid_out !== 1'b0) begin
            failures++;
            $display("FAIL first_idle: valid=%b, required 0", bus.data_valid_out);
        end
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] exp_data;
        int            exp_src;
        apply_reset();
        for (int c = 0; c <= 12; c++) begin
            if (c < 3) begin
                bus.valid_array = '1;
                for (int i = 0; i < N; i++) bus.data_line[i] = DW'(i * 16 + c);
            end else begin
                bus.valid_array = '0;
            end
            tick();
            if (c >= 1) begin
                exp_src  = (c - 1) % 4;
                exp_data = DW'(exp_src * 16 + (c - 1) / 4);
                checks++;
                if (bus.data_valid_out !== 1'b1 || bus.source_out !== 2'(exp_src) ||
                    bus.data_out !== exp_data) begin
                    failures++;
                    $display("FAIL rr_beat%0d: valid=%b src=%0d data=%h, required 1/%0d/%h",
                             c - 1, bus.data_valid_out, bus.source_out, bus.data_out, exp_src, exp_data);
                end
            end
        end
        tick();
        checks++;
        if (bus.data_valid_out !== 1'b0) begin
            failures++;
            $display("FAIL rr_drained: valid=%b, required 0", bus.data_valid_out);
        end
    endtask

    task automatic test_skip();
        logic [DW-1:0] exp_data;
        apply_reset();
        for (int c = 0; c <= 16; c++) begin
            if (c < 16) begin
                bus.valid_array[3] = 1'b1;
                bus.data_line[3]   = DW'(32'h300 + c);
            end else begin
                bus.valid_array = '0;
            end
            tick();
            if (c >= 1) begin
                exp_data = DW'(32'h300 + c - 1);
                checks++;
                if (bus.data_valid_out !== 1'b1 || bus.source_out !== 2'd3 || bus.data_out !== exp_data) begin
                    failures++;
                    $display("FAIL skip_beat%0d: valid=%b src=%0d data=%h, required 1/3/%h",
                             c - 1, bus.data_valid_out, bus.source_out, bus.data_out, exp_data);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int   sent;
        logic acc;
        logic held_ok;
        logic [DW-1:0] exp_data;
        apply_reset();
        bus.receiver_ready = 1'b0;
        sent    = 0;
        held_ok = 1'b1;
        for (int c = 0; c < 40; c++) begin
            bus.valid_array[1] = (sent < 20);
            bus.data_line[1]   = DW'(32'h100 + sent);
            acc = bus.ready_array[1] && bus.valid_array[1];
            tick();
            if (acc) sent++;
            if (c >= 1 && (bus.data_valid_out !== 1'b1 || bus.data_out !== 64'h100 || bus.source_out !== 2'd1))
                held_ok = 1'b0;
        end
        checks++;
        if (sent != 17) begin
            failures++;
            $display("FAIL bp_accepted: accepted=%0d, required 17", sent);
        end
        checks++;
        if (bus.ready_array[1] !== 1'b0 || bus.full_array[1] !== 1'b1) begin
            failures++;
            $display("FAIL bp_full: ready1=%b full1=%b, required 0/1", bus.ready_array[1], bus.full_array[1]);
        end
        checks++;
        if (held_ok !== 1'b1) begin
            failures++;
            $display("FAIL bp_hold: output held=%b, required 1", held_ok);
        end
        bus.valid_array    = '0;
        bus.receiver_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            exp_data = DW'(32'h100 + k);
            checks++;
            if (bus.data_valid_out !== 1'b1 || bus.source_out !== 2'd1 || bus.data_out !== exp_data) begin
                failures++;
                $display("FAIL bp_drain%0d: valid=%b src=%0d data=%h, required 1/1/%h",
                         k, bus.data_valid_out, bus.source_out, bus.data_out, exp_data);
            end
            tick();
        end
        checks++;
        if (bus.data_valid_out !== 1'b0 || bus.ready_array !== 4'hF) begin
            failures++;
            $display("FAIL bp_empty: valid=%b ready=%h, required 0/F", bus.data_valid_out, bus.ready_array);
        end
    endtask

    task automatic test_async_reset();
        logic stale;
        apply_reset();
        bus.receiver_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            bus.valid_array = '1;
            for (int i = 0; i < N; i++) bus.data_line[i] = DW'(32'h500 + i * 16 + c);
            tick();
        end
        checks++;
        if (bus.data_valid_out !== 1'b1) begin
            failures++;
            $display("FAIL async_pre: valid=%b before reset, required 1", bus.data_valid_out);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.data_valid_out !== 1'b0 || bus.ready_array !== 4'hF || bus.full_array !== 4'h0) begin
            failures++;
            $display("FAIL async_assert: valid=%b ready=%h full=%h, required 0/F/0",
                     bus.data_valid_out, bus.ready_array, bus.full_array);
        end
        bus.valid_array = '0;
        tick();
        tick();
        rst_n = 1'b1;
        bus.receiver_ready = 1'b1;
        stale = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bus.data_valid_out !== 1'b0) stale = 1'b1;
        end
        checks++;
        if (stale !== 1'b0) begin
            failures++;
            $display("FAIL async_stale: stale beat seen=%b, required 0", stale);
        end
    endtask

`ifdef RR_ARB_DROP_STATS_EN
    task automatic test_drop_stats();
        int waited;
        apply_reset();
        bus.receiver_ready = 1'b0;
        bus.valid_array[0] = 1'b1;
        bus.data_line[0]   = 64'h77;
        waited = 0;
        while (bus.ready_array[0] === 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        checks++;
        if (bus.ready_array[0] !== 1'b0) begin
            failures++;
            $display("FAIL drop_fill: ready0=%b after %0d cycles, required 0", bus.ready_array[0], waited);
        end
        repeat (5) tick();
        bus.valid_array = '0;
        tick();
        checks++;
        if (drop_count[0] !== 16'd5 || drop_count[1] !== 16'd0) begin
            failures++;
            $display("FAIL drop_count: cnt0=%0d cnt1=%0d, required 5/0", drop_count[0], drop_count[1]);
        end
    endtask
`endif

    initial begin
        bus.valid_array    = '0;
        bus.data_line      = '0;
        bus.receiver_ready = 1'b1;
        test_reset();
        test_first_beat();
        test_round_robin();
        test_skip();
        test_backpressure();
        test_async_reset();
`ifdef RR_ARB_DROP_STATS_EN
        test_drop_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
